// File: rtl/reg_file.sv
// Parametrised register file: one synchronous write port, two asynchronous read
// ports, optional hard-wired zero entry and optional write-to-read bypass.
module reg_file #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] words [DEPTH];
    logic             wr_hit;

    // An address is live if it maps to real storage that is not the protected zero entry.
    function automatic logic addr_live(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range  = (32'(a) < DEPTH);
        is_zero   = ZERO_REG && (a == '0);
        addr_live = in_range && !is_zero;
    endfunction

    always_comb begin
        wr_hit = we && !rst && addr_live(waddr);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [WIDTH-1:0] q;

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (wr_hit && (waddr == AW'(g))) begin
                q <= wdata;
            end
        end

        assign words[g] = q;
    end

    // Dead addresses (zero entry, out of range) read 0 and never bypass.
    always_comb begin
        rdata1 = '0;
        if (addr_live(raddr1)) begin
            if (BYPASS && wr_hit && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = words[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (addr_live(raddr2)) begin
            if (BYPASS && wr_hit && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = words[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench: dut_a is the default build (32 entries, zero entry, no bypass);
// dut_b has 24 entries, no zero entry and bypass, sharing the same stimulus.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] a_rdata1;
    logic [31:0] a_rdata2;
    logic [31:0] b_rdata1;
    logic [31:0] b_rdata2;

    int n_checks;
    int n_fail;

    reg_file dut_a (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (a_rdata1),
        .rdata2 (a_rdata2)
    );

    reg_file #(
        .DEPTH    (24),
        .ZERO_REG (1'b0),
        .BYPASS   (1'b1)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (b_rdata1),
        .rdata2 (b_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        chk;
        logic [31:0] ea1;
        logic [31:0] ea2;
        logic [31:0] eb1;
        logic [31:0] eb2;
    } vec_t;

    localparam int unsigned NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %08h, expected %08h", name, idx, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Expected values are read before the rising edge of each vector's cycle.
        //          rst   we    waddr  wdata         ra1    ra2    chk   a1            a2            b1            b2
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd31, 1'b1, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd31, 32'h12345678, 5'd5,  5'd31, 1'b1, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd6,  5'd30, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  1'b1, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  1'b1, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 1'b1, 5'd7,  32'h00000011, 5'd7,  5'd6,  1'b1, 32'h0,        32'h0,        32'h00000011, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  1'b1, 32'h00000011, 32'h00000011, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[9]  = '{1'b0, 1'b1, 5'd3,  32'h00000055, 5'd3,  5'd7,  1'b1, 32'h0,        32'hA5A5A5A5, 32'h00000055, 32'hA5A5A5A5};
        vecs[10] = '{1'b0, 1'b1, 5'd3,  32'h00000066, 5'd3,  5'd2,  1'b1, 32'h00000055, 32'h0,        32'h00000066, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b1, 32'h00000066, 32'h0,        32'h00000066, 32'hFFFFFFFF};
        vecs[12] = '{1'b1, 1'b1, 5'd3,  32'h00000099, 5'd3,  5'd7,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[13] = '{1'b1, 1'b1, 5'd3,  32'h00000099, 5'd3,  5'd3,  1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[14] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd7,  1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[15] = '{1'b0, 1'b1, 5'd26, 32'h00000077, 5'd26, 5'd2,  1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[16] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd26, 5'd10, 1'b1, 32'h00000077, 32'h0,        32'h0,        32'h0};

        rst    = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset then read every address on both ports.
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check("rst_a1", i, a_rdata1, 32'h0);
            check("rst_a2", i, a_rdata2, 32'h0);
            check("rst_b1", i, b_rdata1, 32'h0);
            check("rst_b2", i, b_rdata2, 32'h0);
        end

        for (int v = 0; v < int'(NVEC); v++) begin
            @(negedge clk);
            rst    = vecs[v].rst;
            we     = vecs[v].we;
            waddr  = vecs[v].waddr;
            wdata  = vecs[v].wdata;
            raddr1 = vecs[v].ra1;
            raddr2 = vecs[v].ra2;
            #2;
            if (vecs[v].chk) begin
                check("vec_a1", v, a_rdata1, vecs[v].ea1);
                check("vec_a2", v, a_rdata2, vecs[v].ea2);
                check("vec_b1", v, b_rdata1, vecs[v].eb1);
                check("vec_b2", v, b_rdata2, vecs[v].eb2);
            end
        end

        // Final sweep: only entry 26 of the 32-entry build holds data; dut_b dropped that write.
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            #1;
            check("sweep_a1", i, a_rdata1, (i == 26) ? 32'h00000077 : 32'h0);
            check("sweep_b2", i, b_rdata2, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-entry register file built from load-enabled storage words: one synchronous write port, two asynchronous read ports, an optional hard-wired zero entry and optional write-to-read bypass. It is the next step up from the single load-enabled N-bit register and serves as the integer register file (x0..x31) of the RISC-V core. Decode drives it with rs1/rs2/rd fields and writeback drives its write port.

## Interface
- WIDTH, 32, data width of every entry in bits (>= 1)
- DEPTH, 32, number of entries (>= 2; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; do not override)
- ZERO_REG, 1, 1: entry 0 reads as zero and ignores writes; 0: entry 0 is ordinary storage
- BYPASS, 0, 1: a read of the address being written this cycle returns wdata; 0: it returns the stored (old) value

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk
- we  input  1  write enable
- waddr  input  AW  write address
- wdata  input  WIDTH  write data
- raddr1  input  AW  read port 1 address
- raddr2  input  AW  read port 2 address
- rdata1  output  WIDTH  read port 1 data (combinational from raddr1 and state)
- rdata2  output  WIDTH  read port 2 data (combinational from raddr2 and state)

## Operation
- Storage: DEPTH words of WIDTH bits, each a load-enabled register. An entry loads wdata iff we=1, waddr equals its index, rst=0, and it is not the protected zero entry. Otherwise it holds its value.
- Reset: a rising edge with rst=1 clears every entry to 0. rst has priority over we: a write in a reset cycle is discarded.
- Read: rdataN = entry[raddrN]. Both ports are independent and may address the same entry.
- Zero entry (ZERO_REG=1):
  - raddrN=0 always returns 0, including under bypass.
  - A write to 0 is ignored and has no side effects.
- Bypass (BYPASS=1): if we=1, rst=0, waddr=raddrN, and the address is not the protected zero entry, then rdataN=wdata combinationally in the same cycle. Both ports bypass independently.
- Out-of-range addresses (value >= DEPTH, possible only when DEPTH is not a power of two):
  - Reads return 0.
  - Writes are ignored.
  - Bypass never applies.
- No X propagation: every output is defined for every input combination once the first reset has occurred.

## Timing
- Write latency: data written at rising edge k is visible on a read port from edge k onward (with BYPASS=0). With BYPASS=1 it is visible from the start of cycle k, before the edge.
- Read latency: zero cycles; combinational path from address and state to data.
- Reset: all entries read 0 from the first rising edge with rst=1. While rst stays high, reads return 0 and bypass is suppressed.
- Reset mid-operation: asserting rst in the same cycle as a write drops the write. The entry reads 0 afterwards.
- Back-to-back writes to the same address: the last write wins; no hazard.
- Simultaneous write and read of the same address, BYPASS=0: the read returns the old value during that cycle and the new value after the edge.

## Test plan
- Reset then read all: assert rst for 1 cycle → rdata1 and rdata2 read 0 for every address 0..DEPTH-1.
- Write/readback: write 0xDEADBEEF to 5 and 0x12345678 to 31 → the next cycle raddr1=5 returns 0xDEADBEEF and raddr2=31 returns 0x12345678. Every other entry still reads 0.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to 0 → rdata1 for raddr1=0 is 0 in the write cycle and afterwards. With ZERO_REG=0 it reads 0xFFFFFFFF after the edge.
- Bypass, same cycle: we=1, waddr=7, wdata=0xA5A5A5A5, raddr1=raddr2=7, entry 7 previously holding 0x11 → with BYPASS=1 both ports return 0xA5A5A5A5 before the edge. With BYPASS=0 both return 0x11 before the edge and 0xA5A5A5A5 after it.
- Reset versus write: write 0x55 to 3, then in one cycle assert rst=1 with we=1, waddr=3, wdata=0x99 → entry 3 reads 0 afterwards, and bypass output is 0 during that cycle.
- Non-power-of-two depth (DEPTH=24, AW=5): write 0x77 to address 26 → no entry changes, and reading address 26 returns 0.
